// File: rtl/line_cond_pkg.sv
// -----------------------------------------------------------------------------
// line_cond_pkg
// Shared definitions for the line conditioner: per-line mode encodings and a
// helper that selects which filtered edge(s) fire the pulse stretcher.
// -----------------------------------------------------------------------------
package line_cond_pkg;

    localparam logic [1:0] LC_MODE_LEVEL = 2'b00;
    localparam logic [1:0] LC_MODE_RISE  = 2'b01;
    localparam logic [1:0] LC_MODE_FALL  = 2'b10;
    localparam logic [1:0] LC_MODE_BOTH  = 2'b11;

    // Level mode never produces an event, so a stale pulse counter is
    // simply left to run down unobserved.
    function automatic logic lc_mode_event(
        input logic [1:0] mode,
        input logic       rise,
        input logic       fall
    );
        logic ev;
        ev = 1'b0;
        case (mode)
            LC_MODE_RISE: ev = rise;
            LC_MODE_FALL: ev = fall;
            LC_MODE_BOTH: ev = rise | fall;
            default:      ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/line_cond_chan.sv
// -----------------------------------------------------------------------------
// line_cond_chan
// One conditioned line: two-flop synchroniser, polarity inversion, glitch
// filter, edge detector and retriggerable pulse stretcher.
//
// Ports:
//   clk           block clock
//   rstn          asynchronous active-low reset
//   raw_line      asynchronous external line
//   invert        polarity inversion applied after the synchroniser
//   mode          output mode (level / rise / fall / both-edge pulse)
//   filter_len    L: input must differ from the filtered state L+1 cycles
//   stretch_len   S: pulse length is S+1 cycles
//   filtered_line debounced level
//   cond_line     conditioned output (level or stretched pulse)
// -----------------------------------------------------------------------------
module line_cond_chan
    import line_cond_pkg::*;
#(
    parameter int FILTER_W  = 8,
    parameter int STRETCH_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 raw_line,
    input  logic                 invert,
    input  logic [1:0]           mode,
    input  logic [FILTER_W-1:0]  filter_len,
    input  logic [STRETCH_W-1:0] stretch_len,
    output logic                 filtered_line,
    output logic                 cond_line
);

    localparam logic [FILTER_W-1:0]  FILT_ONE  = FILTER_W'(1);
    localparam logic [STRETCH_W:0]   PULSE_ONE = (STRETCH_W + 1)'(1);

    logic                 r_sy1;
    logic                 r_sy2;
    logic                 r_filt;
    logic                 r_filt_d;
    logic [FILTER_W-1:0]  r_cnt;
    logic [STRETCH_W:0]   r_pulse;

    logic                 w_s;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_event;

    // Inversion sits after the synchroniser so a polarity change is just
    // another input transition for the filter to judge.
    assign w_s = r_sy2 ^ invert;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sy1 <= 1'b0;
            r_sy2 <= 1'b0;
        end else begin
            r_sy1 <= raw_line;
            r_sy2 <= r_sy1;
        end
    end

    // The compare is >= so lowering filter_len below a running count
    // commits the transition on the next cycle; the count is cleared at
    // that point and therefore never wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (w_s == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt >= filter_len) begin
            r_filt <= w_s;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + FILT_ONE;
        end
    end

    // f and f_d both reset to 0, so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= r_filt;
        end
    end

    assign w_rise  = r_filt & ~r_filt_d;
    assign w_fall  = ~r_filt & r_filt_d;
    assign w_event = lc_mode_event(mode, w_rise, w_fall);

    // Retrigger reloads rather than accumulates; the extra counter bit
    // holds S+1 without overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pulse <= '0;
        end else if (w_event) begin
            r_pulse <= {1'b0, stretch_len} + PULSE_ONE;
        end else if (r_pulse != '0) begin
            r_pulse <= r_pulse - PULSE_ONE;
        end
    end

    assign filtered_line = r_filt;
    assign cond_line     = (mode == LC_MODE_LEVEL) ? r_filt : (r_pulse != '0);

endmodule

// File: rtl/line_conditioner.sv
// -----------------------------------------------------------------------------
// line_conditioner
// Per-line input conditioner feeding the line routing matrix. Replicates one
// line_cond_chan per line and slices the per-line configuration.
//
// Ports:
//   clk            block clock
//   rstn           asynchronous active-low reset
//   raw_lines      asynchronous external lines
//   invert         per-line polarity inversion
//   mode           per-line mode, bits [2i+1:2i]
//   filter_len     shared glitch-filter length L
//   stretch_len    shared pulse-stretch length S
//   filtered_lines debounced level per line
//   cond_lines     conditioned outputs to the matrix input_lines
// -----------------------------------------------------------------------------
module line_conditioner
    import line_cond_pkg::*;
#(
    parameter int NUM_LINES = 10,
    parameter int FILTER_W  = 8,
    parameter int STRETCH_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_LINES-1:0]   raw_lines,
    input  logic [NUM_LINES-1:0]   invert,
    input  logic [2*NUM_LINES-1:0] mode,
    input  logic [FILTER_W-1:0]    filter_len,
    input  logic [STRETCH_W-1:0]   stretch_len,
    output logic [NUM_LINES-1:0]   filtered_lines,
    output logic [NUM_LINES-1:0]   cond_lines
);

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        line_cond_chan #(
            .FILTER_W  (FILTER_W),
            .STRETCH_W (STRETCH_W)
        ) u_chan (
            .clk           (clk),
            .rstn          (rstn),
            .raw_line      (raw_lines[g]),
            .invert        (invert[g]),
            .mode          (mode[2*g +: 2]),
            .filter_len    (filter_len),
            .stretch_len   (stretch_len),
            .filtered_line (filtered_lines[g]),
            .cond_line     (cond_lines[g])
        );
    end

endmodule

// File: tb/tb_line_conditioner.sv
// -----------------------------------------------------------------------------
// tb_line_conditioner
// Directed-vector bench for line_conditioner. Inputs are driven 1 time unit
// after a rising edge ("edge k"); outputs are sampled 1 time unit after later
// edges, so "after n ticks" corresponds to edge k+n.
// -----------------------------------------------------------------------------
module tb_line_conditioner;
    import line_cond_pkg::*;

    localparam int NUM_LINES = 10;
    localparam int FILTER_W  = 8;
    localparam int STRETCH_W = 8;

    logic                   clk;
    logic                   rstn;
    logic [NUM_LINES-1:0]   raw_lines;
    logic [NUM_LINES-1:0]   invert;
    logic [2*NUM_LINES-1:0] mode;
    logic [FILTER_W-1:0]    filter_len;
    logic [STRETCH_W-1:0]   stretch_len;
    logic [NUM_LINES-1:0]   filtered_lines;
    logic [NUM_LINES-1:0]   cond_lines;

    int checkCount;
    int passCount;

    line_conditioner #(
        .NUM_LINES (NUM_LINES),
        .FILTER_W  (FILTER_W),
        .STRETCH_W (STRETCH_W)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .raw_lines      (raw_lines),
        .invert         (invert),
        .mode           (mode),
        .filter_len     (filter_len),
        .stretch_len    (stretch_len),
        .filtered_lines (filtered_lines),
        .cond_lines     (cond_lines)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Apply a new raw line vector, optionally with new shared lengths.
    task automatic applyStimulus(input logic [NUM_LINES-1:0] raw,
                                 input logic [FILTER_W-1:0] l,
                                 input logic [STRETCH_W-1:0] s);
        raw_lines   = raw;
        filter_len  = l;
        stretch_len = s;
    endtask

    initial begin
        checkCount  = 0;
        passCount   = 0;
        rstn        = 1'b0;
        raw_lines   = '0;
        invert      = '0;
        filter_len  = '0;
        stretch_len = '0;
        mode        = '0;
        mode[2*2 +: 2] = LC_MODE_FALL;
        mode[2*3 +: 2] = LC_MODE_RISE;
        mode[2*4 +: 2] = LC_MODE_BOTH;
        mode[2*5 +: 2] = LC_MODE_RISE;
        mode[2*6 +: 2] = LC_MODE_RISE;

        // Reset state
        tick(2);
        checkOutput("reset_cond", 32'(cond_lines), 32'h0);
        checkOutput("reset_filt", 32'(filtered_lines), 32'h0);
        rstn = 1'b1;
        tick(3);

        // Level mode, L=0: raw[0] rises, output at k+3
        $display("[TB] level latency L=0");
        applyStimulus(10'b00_0000_0001, 8'd0, 8'd0);
        tick(2);
        checkOutput("lvl_k2", 32'(cond_lines), 32'h0);
        tick(1);
        checkOutput("lvl_k3", 32'(cond_lines), 32'h1);
        tick(5);
        checkOutput("lvl_hold", 32'(cond_lines), 32'h1);
        checkOutput("lvl_filt", 32'(filtered_lines), 32'h1);

        // L=4: 4-cycle pulse rejected, 5-cycle pulse accepted at k+7
        $display("[TB] glitch filter L=4");
        applyStimulus(10'b00_0000_0011, 8'd4, 8'd0);
        tick(4);
        applyStimulus(10'b00_0000_0001, 8'd4, 8'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checkOutput("glitch_reject", 32'(filtered_lines[1]), 32'h0);
        end
        tick(6);
        applyStimulus(10'b00_0000_0011, 8'd4, 8'd0);
        tick(5);
        applyStimulus(10'b00_0000_0001, 8'd4, 8'd0);
        tick(1);
        checkOutput("glitch_k6", 32'(filtered_lines[1]), 32'h0);
        tick(1);
        checkOutput("glitch_k7", 32'(filtered_lines[1]), 32'h1);
        checkOutput("glitch_cond_k7", 32'(cond_lines[1]), 32'h1);
        tick(20);
        checkOutput("glitch_fall", 32'(filtered_lines[1]), 32'h0);

        // Rise pulse S=3 with retrigger: raw[3] 1,0,1 on successive cycles
        $display("[TB] rise pulse with retrigger");
        applyStimulus(10'b00_0000_1001, 8'd0, 8'd3);
        tick(1);
        applyStimulus(10'b00_0000_0001, 8'd0, 8'd3);
        tick(1);
        applyStimulus(10'b00_0000_1001, 8'd0, 8'd3);
        // now at edge k+2
        for (int n = 3; n <= 11; n++) begin
            tick(1);
            checkOutput($sformatf("retrig_k%0d", n), 32'(cond_lines[3]),
                        32'((n >= 4 && n <= 9) ? 1 : 0));
        end
        tick(10);

        // Both-edge, S=0, L=2: one 1-cycle pulse at k+6 per transition
        $display("[TB] both-edge pulses");
        applyStimulus(raw_lines, 8'd2, 8'd0);
        tick(5);
        for (int t = 0; t < 3; t++) begin
            logic [NUM_LINES-1:0] nextRaw;
            nextRaw    = raw_lines;
            nextRaw[4] = ~nextRaw[4];
            applyStimulus(nextRaw, 8'd2, 8'd0);
            for (int n = 1; n <= 10; n++) begin
                tick(1);
                checkOutput($sformatf("both_t%0d_k%0d", t, n), 32'(cond_lines[4]),
                            32'((n == 6) ? 1 : 0));
            end
        end
        tick(5);

        // Invert on lines 2 (fall mode) and 5 (rise mode) with raw low, L=1
        $display("[TB] polarity inversion");
        applyStimulus(raw_lines, 8'd1, 8'd0);
        tick(2);
        invert[2] = 1'b1;
        invert[5] = 1'b1;
        tick(1);
        checkOutput("inv_f_k1", 32'(filtered_lines[2]), 32'h0);
        tick(1);
        checkOutput("inv_f_k2", 32'(filtered_lines[2]), 32'h1);
        checkOutput("inv_f5_k2", 32'(filtered_lines[5]), 32'h1);
        checkOutput("inv_p5_k2", 32'(cond_lines[5]), 32'h0);
        tick(1);
        checkOutput("inv_p5_k3", 32'(cond_lines[5]), 32'h1);
        checkOutput("inv_p2_k3", 32'(cond_lines[2]), 32'h0);
        tick(1);
        checkOutput("inv_p5_k4", 32'(cond_lines[5]), 32'h0);
        checkOutput("inv_p2_k4", 32'(cond_lines[2]), 32'h0);
        tick(10);

        // Reset mid-pulse (line 6, p=5) and mid-filter (line 7, c=3), L=6, S=10
        $display("[TB] asynchronous reset");
        applyStimulus(raw_lines, 8'd6, 8'd10);
        tick(2);
        begin
            logic [NUM_LINES-1:0] nextRaw;
            nextRaw    = raw_lines;
            nextRaw[6] = 1'b1;
            applyStimulus(nextRaw, 8'd6, 8'd10);
            tick(10);
            checkOutput("rst_pulse_k10", 32'(cond_lines[6]), 32'h1);
            tick(1);
            nextRaw[7] = 1'b1;
            applyStimulus(nextRaw, 8'd6, 8'd10);
            tick(5);
        end
        checkOutput("rst_pulse_k16", 32'(cond_lines[6]), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst_async_cond", 32'(cond_lines), 32'h0);
        checkOutput("rst_async_filt", 32'(filtered_lines), 32'h0);
        tick(2);
        checkOutput("rst_hold_cond", 32'(cond_lines), 32'h0);
        rstn = 1'b1;
        tick(8);
        checkOutput("rel_lvl_k8", 32'(cond_lines[0]), 32'h0);
        tick(1);
        checkOutput("rel_lvl_k9", 32'(cond_lines[0]), 32'h1);
        checkOutput("rel_f7_k9", 32'(filtered_lines[7]), 32'h1);
        checkOutput("rel_p6_k9", 32'(cond_lines[6]), 32'h0);
        tick(1);
        checkOutput("rel_p6_k10", 32'(cond_lines[6]), 32'h1);
        tick(10);
        checkOutput("rel_p6_k20", 32'(cond_lines[6]), 32'h1);
        tick(1);
        checkOutput("rel_p6_k21", 32'(cond_lines[6]), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
